lsu_mem_port: RTL

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port_pkg.sv | 44 ++++
 rtl/lsu_mem_port_align.sv | 48 ++++
 rtl/lsu_mem_port.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_pkg.sv
// Shared load/store code constants, LSU FSM state type and the access legality check.
package lsu_mem_port_pkg;

  localparam logic [2:0] MEM_READ_NONE = 3'b000;
  localparam logic [2:0] MEM_READ_LW   = 3'b001;
  localparam logic [2:0] MEM_READ_LH   = 3'b110;
  localparam logic [2:0] MEM_READ_LB   = 3'b111;
  localparam logic [2:0] MEM_READ_LBU  = 3'b011;
  localparam logic [2:0] MEM_READ_LHU  = 3'b010;

  localparam logic [1:0] MEM_WRITE_NONE = 2'b00;
  localparam logic [1:0] MEM_WRITE_SW   = 2'b01;
  localparam logic [1:0] MEM_WRITE_SH   = 2'b10;
  localparam logic [1:0] MEM_WRITE_SB   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  // Rejects mixed load+store, unknown load codes and misaligned word/half accesses.
  function automatic logic op_illegal(input logic [2:0] mem_read,
                                      input logic [1:0] mem_write,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (mem_read != MEM_READ_NONE && mem_write != MEM_WRITE_NONE) bad = 1'b1;
    case (mem_read)
      MEM_READ_LW:                if (addr_lo != 2'b00) bad = 1'b1;
      MEM_READ_LH, MEM_READ_LHU:  if (addr_lo[0]) bad = 1'b1;
      MEM_READ_LB, MEM_READ_LBU,
      MEM_READ_NONE:              ;
      default:                    bad = 1'b1;
    endcase
    case (mem_write)
      MEM_WRITE_SW: if (addr_lo != 2'b00) bad = 1'b1;
      MEM_WRITE_SH: if (addr_lo[0]) bad = 1'b1;
      default:      ;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_port_align.sv
// Byte-lane steering: write strobes, store data replication and load extraction.
module lsu_align
  import lsu_mem_port_pkg::*;
(
  input  logic [2:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = rdata[{addr_lo, 3'b000} +: 8];
    half_sel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wstrb       = 4'b0000;
    wdata_lanes = wdata;
    load_data   = 32'h0;

    case (mem_write)
      MEM_WRITE_SW: wstrb = 4'b1111;
      MEM_WRITE_SH: begin
        wstrb       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
      end
      MEM_WRITE_SB: begin
        wstrb       = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      default: ;
    endcase

    case (mem_read)
      MEM_READ_LW:  load_data = rdata;
      MEM_READ_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      MEM_READ_LHU: load_data = {16'h0, half_sel};
      MEM_READ_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_READ_LBU: load_data = {24'h0, byte_sel};
      default:      load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one core request at a time onto a word-addressed bus.
// Handshake: an operation transfers when req_valid && req_ready; req_ready is high only in IDLE.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_mem_read,
  input  logic [1:0]  req_mem_write,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output lsu_state_t  dbg_state
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  logic [2:0]       op_read;
  logic [1:0]       op_write;
  logic [CNT_W-1:0] tmo_cnt;
  logic [3:0]       lane_strb;
  logic [31:0]      lane_wdata;
  logic [31:0]      load_data;
  logic             accept;

  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  lsu_align u_align (
    .mem_read    (op_read),
    .mem_write   (op_write),
    .addr_lo     (op_addr[1:0]),
    .wdata       (op_wdata),
    .rdata       (bus_rdata),
    .wstrb       (lane_strb),
    .wdata_lanes (lane_wdata),
    .load_data   (load_data)
  );

  // Bus fields come straight from the latched operation, so they cannot move while bus_req is up.
  assign bus_addr  = bus_req ? {op_addr[31:2], 2'b00} : 32'h0;
  assign bus_wstrb = (bus_req && bus_we) ? lane_strb : 4'b0000;
  assign bus_wdata = (bus_req && bus_we) ? lane_wdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      op_addr    <= 32'h0;
      op_wdata   <= 32'h0;
      op_read    <= MEM_READ_NONE;
      op_write   <= MEM_WRITE_NONE;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            op_addr   <= req_addr;
            op_wdata  <= req_wdata;
            op_read   <= req_mem_read;
            op_write  <= req_mem_write;
            if (op_illegal(req_mem_read, req_mem_write, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_mem_read == MEM_READ_NONE && req_mem_write == MEM_WRITE_NONE) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'h0;
            end else begin
              state   <= ST_BUS;
              bus_req <= 1'b1;
              bus_we  <= (req_mem_write != MEM_WRITE_NONE);
              tmo_cnt <= '0;
            end
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            state      <= ST_RESP;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= bus_we ? 32'h0 : load_data;
          end else if (tmo_cnt == CNT_LAST) begin
            state      <= ST_RESP;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
